// File: rtl/bp_ftq_pkg.sv
// Shared frontend types for the fetch target queue and the branch predictor.
// The struct field widths come from the package constants below; bp_ftq
// defaults its VLEN/IDX_BITS parameters to these values.
package bp_ftq_pkg;

    localparam int FTQ_VLEN     = 64;
    localparam int FTQ_IDX_BITS = 9;
    localparam int FTQ_DEPTH    = 8;

    // One queued fetch block as recorded at prediction time.
    typedef struct packed {
        logic                    valid;
        logic [FTQ_VLEN-1:0]     vpc;
        logic [FTQ_IDX_BITS-1:0] index;
        logic                    unaligned;
    } ftq_entry_t;

    // Training request handed to the predictor's update port.
    typedef struct packed {
        logic                    valid;
        logic [FTQ_VLEN-1:0]     pc;
        logic                    taken;
        logic [FTQ_IDX_BITS-1:0] index;
        logic                    unaligned;
    } ftq_update_t;

endpackage

// File: rtl/bp_ftq.sv
// bp_ftq: fetch target queue for the global branch predictor.
// Records {vpc, predictor index, unaligned} per fetch block, returns the saved
// index when execute resolves a branch, retires in order and squashes on
// mispredict.
// Optional feature: define BP_FTQ_UPDATE_REG_EN to register the upd_* and
// resolve_drop_o outputs (one cycle latency); otherwise they are combinational.
module bp_ftq
    import bp_ftq_pkg::*;
#(
    parameter int VLEN     = FTQ_VLEN,
    parameter int IDX_BITS = FTQ_IDX_BITS,
    parameter int DEPTH    = FTQ_DEPTH,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                debug_mode_i,
    input  logic                push_valid_i,
    output logic                push_ready_o,
    input  logic [VLEN-1:0]     push_vpc_i,
    input  logic [IDX_BITS-1:0] push_index_i,
    input  logic                push_unaligned_i,
    output logic [PTR_BITS-1:0] push_id_o,
    input  logic                resolve_valid_i,
    input  logic [PTR_BITS-1:0] resolve_id_i,
    input  logic [VLEN-1:0]     resolve_pc_i,
    input  logic                resolve_taken_i,
    input  logic                resolve_mispredict_i,
    input  logic                commit_i,
    output logic                upd_valid_o,
    output logic [VLEN-1:0]     upd_pc_o,
    output logic                upd_taken_o,
    output logic [IDX_BITS-1:0] upd_index_o,
    output logic                upd_unaligned_o,
    output logic                resolve_drop_o,
    output logic [PTR_BITS:0]   count_o
);

    localparam logic [PTR_BITS:0] PTR_ZERO = {(PTR_BITS+1){1'b0}};
    localparam logic [PTR_BITS:0] PTR_ONE  = {{PTR_BITS{1'b0}}, 1'b1};

    logic [PTR_BITS:0]   head_q, head_d;
    logic [PTR_BITS:0]   tail_q, tail_d;
    ftq_entry_t          entries_q [DEPTH];
    ftq_entry_t          entries_d [DEPTH];

    logic                empty_s;
    logic                full_s;
    logic                push_accept_s;
    logic                hit_s;
    logic                squash_s;
    logic [PTR_BITS-1:0] rel_s;
    logic [PTR_BITS:0]   squash_tail_s;
    logic [PTR_BITS:0]   kill_cnt_s;
    logic [DEPTH-1:0]    kill_mask_s;
    ftq_update_t         upd_s;
    logic                drop_s;

    // Occupancy, push handshake and resolve lookup against the current array.
    always_comb begin
        empty_s       = (head_q == tail_q);
        full_s        = (head_q[PTR_BITS-1:0] == tail_q[PTR_BITS-1:0]) &&
                        (head_q[PTR_BITS] != tail_q[PTR_BITS]);
        push_ready_o  = !full_s && !flush_i && !(resolve_valid_i && resolve_mispredict_i);
        push_accept_s = push_valid_i && push_ready_o;
        hit_s         = resolve_valid_i && entries_q[resolve_id_i].valid;
        squash_s      = hit_s && resolve_mispredict_i && !flush_i;
        // Distance of the resolved entry from head, so the wrap bit of the
        // new tail follows head rather than the raw slot id.
        rel_s         = resolve_id_i - head_q[PTR_BITS-1:0];
        squash_tail_s = head_q + {1'b0, rel_s} + PTR_ONE;
        kill_cnt_s    = tail_q - squash_tail_s;
    end

    // Slots lying in [new tail, old tail) are the ones a mispredict discards.
    always_comb begin
        kill_mask_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            kill_mask_s[i] = ({1'b0, PTR_BITS'(PTR_BITS'(i) - squash_tail_s[PTR_BITS-1:0])}
                              < kill_cnt_s);
        end
    end

    // Next queue state: flush beats mispredict beats push; commit is independent.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        entries_d = entries_q;
        if (flush_i) begin
            head_d = PTR_ZERO;
            tail_d = PTR_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
            end
        end else begin
            if (commit_i && !empty_s) begin
                entries_d[head_q[PTR_BITS-1:0]].valid = 1'b0;
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            if (squash_s) begin
                tail_d = squash_tail_s;
                for (int i = 0; i < DEPTH; i++) begin
                    if (kill_mask_s[i]) begin
                        entries_d[i].valid = 1'b0;
                    end else begin
                        entries_d[i].valid = entries_d[i].valid;
                    end
                end
            end else if (push_accept_s) begin
                entries_d[tail_q[PTR_BITS-1:0]].valid     = 1'b1;
                entries_d[tail_q[PTR_BITS-1:0]].vpc       = push_vpc_i;
                entries_d[tail_q[PTR_BITS-1:0]].index     = push_index_i;
                entries_d[tail_q[PTR_BITS-1:0]].unaligned = push_unaligned_i;
                tail_d = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // Queue pointers and entry array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= PTR_ZERO;
            tail_q    <= PTR_ZERO;
            entries_q <= '{default: '0};
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

    // Update request and drop pulse derived from the current resolve.
    always_comb begin
        upd_s       = '0;
        upd_s.valid = hit_s && !debug_mode_i && !flush_i;
        drop_s      = resolve_valid_i && !entries_q[resolve_id_i].valid && !flush_i;
        if (hit_s) begin
            upd_s.pc        = resolve_pc_i;
            upd_s.taken     = resolve_taken_i;
            upd_s.index     = entries_q[resolve_id_i].index;
            upd_s.unaligned = entries_q[resolve_id_i].unaligned;
        end else begin
            upd_s.pc        = {VLEN{1'b0}};
            upd_s.taken     = 1'b0;
            upd_s.index     = {IDX_BITS{1'b0}};
            upd_s.unaligned = 1'b0;
        end
    end

`ifdef BP_FTQ_UPDATE_REG_EN
    ftq_update_t upd_q, upd_d;
    logic        drop_q, drop_d;

    // Strobes reload every cycle; the payload only changes on a live resolve.
    always_comb begin
        upd_d       = upd_q;
        upd_d.valid = upd_s.valid;
        drop_d      = drop_s;
        if (hit_s) begin
            upd_d.pc        = upd_s.pc;
            upd_d.taken     = upd_s.taken;
            upd_d.index     = upd_s.index;
            upd_d.unaligned = upd_s.unaligned;
        end else begin
            upd_d.pc        = upd_q.pc;
        end
    end

    // Output register that cuts the execute-to-predictor path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            upd_q  <= upd_d;
            drop_q <= drop_d;
        end
    end

    assign upd_valid_o     = upd_q.valid;
    assign upd_pc_o        = upd_q.pc;
    assign upd_taken_o     = upd_q.taken;
    assign upd_index_o     = upd_q.index;
    assign upd_unaligned_o = upd_q.unaligned;
    assign resolve_drop_o  = drop_q;
`else
    assign upd_valid_o     = upd_s.valid;
    assign upd_pc_o        = upd_s.pc;
    assign upd_taken_o     = upd_s.taken;
    assign upd_index_o     = upd_s.index;
    assign upd_unaligned_o = upd_s.unaligned;
    assign resolve_drop_o  = drop_s;
`endif

    assign push_id_o = tail_q[PTR_BITS-1:0];
    assign count_o   = tail_q - head_q;

endmodule

// File: tb/tb_bp_ftq.sv
// Self-checking bench for bp_ftq: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_bp_ftq;

    localparam int VLEN     = 64;
    localparam int IDX_BITS = 9;
    localparam int DEPTH    = 8;
    localparam int PTR_BITS = 3;
`ifdef BP_FTQ_UPDATE_REG_EN
    localparam bit REG_MODE = 1'b1;
`else
    localparam bit REG_MODE = 1'b0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                flush_i, debug_mode_i, push_valid_i, push_unaligned_i;
    logic                push_ready_o;
    logic [VLEN-1:0]     push_vpc_i;
    logic [IDX_BITS-1:0] push_index_i;
    logic [PTR_BITS-1:0] push_id_o;
    logic                resolve_valid_i, resolve_taken_i, resolve_mispredict_i, commit_i;
    logic [PTR_BITS-1:0] resolve_id_i;
    logic [VLEN-1:0]     resolve_pc_i;
    logic                upd_valid_o, upd_taken_o, upd_unaligned_o, resolve_drop_o;
    logic [VLEN-1:0]     upd_pc_o;
    logic [IDX_BITS-1:0] upd_index_o;
    logic [PTR_BITS:0]   count_o;

    bp_ftq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_vpc_i(push_vpc_i),
        .push_index_i(push_index_i), .push_unaligned_i(push_unaligned_i), .push_id_o(push_id_o),
        .resolve_valid_i(resolve_valid_i), .resolve_id_i(resolve_id_i),
        .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
        .resolve_mispredict_i(resolve_mispredict_i), .commit_i(commit_i),
        .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o), .upd_taken_o(upd_taken_o),
        .upd_index_o(upd_index_o), .upd_unaligned_o(upd_unaligned_o),
        .resolve_drop_o(resolve_drop_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: live entries oldest first; ids are slot numbers.
    typedef struct {
        int                  id;
        logic [IDX_BITS-1:0] index;
        logic                unal;
    } ment_t;
    ment_t q[$];
    int    mhead = 0;

    typedef struct packed {
        logic                valid;
        logic [VLEN-1:0]     pc;
        logic                taken;
        logic [IDX_BITS-1:0] index;
        logic                unal;
        logic                drop;
    } exp_t;
    exp_t prev_exp = '0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        flush_i = 1'b0; debug_mode_i = 1'b0; push_valid_i = 1'b0;
        push_vpc_i = '0; push_index_i = '0; push_unaligned_i = 1'b0;
        resolve_valid_i = 1'b0; resolve_id_i = '0; resolve_pc_i = '0;
        resolve_taken_i = 1'b0; resolve_mispredict_i = 1'b0; commit_i = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int   pos;
        int   tail_id;
        bit   ready;
        exp_t cur, shown;
        @(negedge clk_i);
        tail_id = (mhead + q.size()) % DEPTH;
        ready = (q.size() < DEPTH) && !flush_i && !(resolve_valid_i && resolve_mispredict_i);
        chk("push_ready", 64'(push_ready_o), 64'(ready));
        chk("push_id", 64'(push_id_o), 64'(tail_id));
        chk("count", 64'(count_o), 64'(q.size()));
        pos = -1;
        if (resolve_valid_i) begin
            for (int j = 0; j < q.size(); j++) begin
                if (q[j].id == int'(resolve_id_i)) pos = j;
            end
        end
        cur = '0;
        cur.drop  = resolve_valid_i && (pos < 0) && !flush_i;
        cur.valid = (pos >= 0) && !debug_mode_i && !flush_i;
        if (cur.valid) begin
            cur.pc    = resolve_pc_i;
            cur.taken = resolve_taken_i;
            cur.index = q[pos].index;
            cur.unal  = q[pos].unal;
        end
        shown = REG_MODE ? prev_exp : cur;
        chk("upd_valid", 64'(upd_valid_o), 64'(shown.valid));
        chk("resolve_drop", 64'(resolve_drop_o), 64'(shown.drop));
        if (shown.valid) begin
            chk("upd_pc", upd_pc_o, shown.pc);
            chk("upd_taken", 64'(upd_taken_o), 64'(shown.taken));
            chk("upd_index", 64'(upd_index_o), 64'(shown.index));
            chk("upd_unaligned", 64'(upd_unaligned_o), 64'(shown.unal));
        end
        prev_exp = cur;
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
            mhead = 0;
        end else begin
            if (resolve_valid_i && resolve_mispredict_i && pos >= 0) begin
                while (q.size() > pos + 1) void'(q.pop_back());
            end
            if (commit_i && q.size() > 0) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % DEPTH;
            end
            if (push_valid_i && ready) begin
                q.push_back('{id: tail_id, index: push_index_i, unal: push_unaligned_i});
            end
        end
        #1;
        set_idle();
        #1;
    endtask

    task automatic do_push(input logic [IDX_BITS-1:0] idx, input logic u);
        push_valid_i = 1'b1; push_index_i = idx; push_unaligned_i = u;
        push_vpc_i = {$urandom, $urandom};
        step();
    endtask

    task automatic do_commit();
        commit_i = 1'b1;
        step();
    endtask

    task automatic do_resolve(input logic [PTR_BITS-1:0] id, input logic [VLEN-1:0] pc,
                              input logic taken, input logic misp);
        resolve_valid_i = 1'b1; resolve_id_i = id; resolve_pc_i = pc;
        resolve_taken_i = taken; resolve_mispredict_i = misp;
        step();
    endtask

    initial begin
        set_idle();
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_ready", 64'(push_ready_o), 64'd1);
        chk("reset_upd_valid", 64'(upd_valid_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        step();

        // Fill and drain.
        for (int i = 0; i < 8; i++) do_push(9'h10 + 9'(i), 1'b0);
        chk("fill_count", 64'(count_o), 64'd8);
        chk("fill_ready", 64'(push_ready_o), 64'd0);
        do_push(9'h1FF, 1'b1);
        for (int i = 0; i < 8; i++) do_commit();
        chk("drain_count", 64'(count_o), 64'd0);
        chk("drain_ready", 64'(push_ready_o), 64'd1);

        // Resolve lookup on id 3.
        for (int i = 0; i < 3; i++) do_push(9'(i), 1'b0);
        chk("lookup_push_id", 64'(push_id_o), 64'd3);
        do_push(9'h1A5, 1'b1);
        do_resolve(3'd3, 64'h8000_0046, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) do_commit();

        // Mispredict squash across the wrap, head at 6.
        do_push(9'h0AA, 1'b0); do_push(9'h0AB, 1'b0);
        do_commit(); do_commit();
        chk("wrap_head_id", 64'(push_id_o), 64'd6);
        for (int i = 0; i < 5; i++) do_push(9'h120 + 9'(i), 1'(i));
        do_resolve(3'd7, 64'h4000_1000, 1'b0, 1'b1);
        chk("wrap_count", 64'(count_o), 64'd2);
        chk("wrap_push_id", 64'(push_id_o), 64'd0);
        do_resolve(3'd1, 64'h4000_2000, 1'b1, 1'b0);
        step();

        // Push colliding with a mispredict, then commit + mispredict on head.
        push_valid_i = 1'b1; push_index_i = 9'h077;
        do_resolve(3'd7, 64'h4000_3000, 1'b1, 1'b1);
        chk("conflict_count", 64'(count_o), 64'd2);
        commit_i = 1'b1;
        do_resolve(3'd6, 64'h4000_4000, 1'b0, 1'b1);
        chk("head_squash_count", 64'(count_o), 64'd0);
        step();

        // Debug suppression and flush with a concurrent resolve.
        do_push(9'h155, 1'b1);
        debug_mode_i = 1'b1;
        do_resolve(3'd7, 64'h4000_5000, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 4; i++) do_push(9'h160 + 9'(i), 1'b0);
        chk("pre_flush_count", 64'(count_o), 64'd5);
        flush_i = 1'b1;
        do_resolve(3'd0, 64'h4000_6000, 1'b1, 1'b0);
        chk("flush_count", 64'(count_o), 64'd0);
        step();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            push_valid_i         = ($urandom_range(0, 99) < 55);
            push_index_i         = 9'($urandom);
            push_unaligned_i     = 1'($urandom);
            push_vpc_i           = {$urandom, $urandom};
            resolve_valid_i      = ($urandom_range(0, 99) < 45);
            resolve_id_i         = 3'($urandom);
            resolve_pc_i         = {$urandom, $urandom};
            resolve_taken_i      = 1'($urandom);
            resolve_mispredict_i = ($urandom_range(0, 99) < 20);
            commit_i             = ($urandom_range(0, 99) < 35);
            debug_mode_i         = ($urandom_range(0, 99) < 8);
            flush_i              = ($urandom_range(0, 99) < 3);
            step();
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_ftq.md
# bp_ftq

Fetch target queue for the global branch predictor. For every fetch block the frontend issues, it records:
- the predictor index computed at prediction time;
- the fetch vpc;
- the unaligned flag.

When execute resolves a branch, the queue returns that saved index so the predictor trains the same counter it read. It sits between the frontend/predictor output (`index_o`) and the predictor's update port (`update_index_i`, `update_is_unaligned_i`, `bht_update_i`). It also handles in-order retirement and squash on mispredict.

## Interface
- `VLEN`, 64: virtual address width.
- `IDX_BITS`, 9: predictor index width.
- `DEPTH`, 8: entries; power of two, ≥2.
- `PTR_BITS`, $clog2(DEPTH): id width. Pointers are PTR_BITS+1 wide (extra wrap bit).

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  full flush; empties the queue.
- `debug_mode_i`  in  1  suppresses predictor updates.
- `push_valid_i`  in  1  frontend offers a fetch block.
- `push_ready_o`  out  1  entry accepted this cycle.
- `push_vpc_i`  in  VLEN  fetch vpc.
- `push_index_i`  in  IDX_BITS  predictor index.
- `push_unaligned_i`  in  1  block begins with an unaligned half instruction.
- `push_id_o`  out  PTR_BITS  id given to the pushed entry (the tail slot).
- `resolve_valid_i`  in  1  a branch has resolved.
- `resolve_id_i`  in  PTR_BITS  entry the branch belongs to.
- `resolve_pc_i`  in  VLEN  branch pc.
- `resolve_taken_i`  in  1  resolved direction.
- `resolve_mispredict_i`  in  1  squash entries younger than `resolve_id_i`.
- `commit_i`  in  1  retire the head entry.
- `upd_valid_o`  out  1  predictor update strobe.
- `upd_pc_o`  out  VLEN  branch pc to train.
- `upd_taken_o`  out  1  direction to train.
- `upd_index_o`  out  IDX_BITS  saved predictor index.
- `upd_unaligned_o`  out  1  saved unaligned flag.
- `resolve_drop_o`  out  1  a resolve targeted an entry that is not live.
- `count_o`  out  PTR_BITS+1  live entries.

## Operation
- **State:** `head_q`, `tail_q` (PTR_BITS+1 each) and a per-entry array {valid, vpc, index, unaligned}.
  - empty: `head_q == tail_q`.
  - full: slot bits equal and wrap bits differ.
  - `count_o = tail_q - head_q` (modular).
- **Push:**
  - `push_ready_o = !full && !flush_i && !(resolve_valid_i && resolve_mispredict_i)`.
  - On accept: write slot `tail_q[PTR_BITS-1:0]`, set valid, increment `tail_q`.
  - `push_id_o = tail_q[PTR_BITS-1:0]` at all times.
- **Resolve:**
  - If `entry[resolve_id_i].valid`: produce an update with pc/taken from the inputs and index/unaligned from the entry.
  - If the entry is not valid: no update; `resolve_drop_o` pulses for one cycle.
  - `upd_valid_o` is forced low while `debug_mode_i` is high. The squash still happens.
- **Mispredict (valid resolve):**
  - New tail = `head_q + ((resolve_id_i - head_q[PTR_BITS-1:0]) mod DEPTH) + 1`, computed at PTR_BITS+1 width.
  - Valid bits of all slots from the new tail up to the old tail are cleared.
- **Commit:**
  - If not empty: clear head valid and increment `head_q`.
  - If empty: ignored, no state change.
- **Priority:** `flush_i` > mispredict > push.
  - Commit and resolve in the same cycle are independent.
  - Commit of the head plus a mispredict on the head yields an empty queue (`head = tail = id+1`).
- **Flush:** `head_q = tail_q = 0`, all valid bits cleared, the pending update is cancelled. Entry payloads need not be cleared.

## Timing
- **Reset values:** all outputs 0 except `push_ready_o = 1` and `push_id_o = 0`. Pointers 0, valid bits 0.
- **Push:** visible to resolve the cycle after acceptance. A resolve to an id pushed in the same cycle is a drop.
- **Update latency:** 1 cycle from resolve to `upd_*` (with `BP_FTQ_UPDATE_REG_EN`), else 0 cycles.
- **Flush mid-update:** a resolve in the flush cycle produces no update. With the register enabled, `upd_valid_o` is 0 in the cycle after flush.

## Configuration
- **`BP_FTQ_UPDATE_REG_EN` defined:** `upd_*` and `resolve_drop_o` come from flops loaded on resolve. This breaks the execute→predictor timing path.
- **Undefined:** `upd_*` and `resolve_drop_o` are combinational from the resolve inputs and the array read.
  - Queue state timing is identical in both modes.

## Structure
- **Shared package:** `ftq_entry_t` {valid, vpc, index, unaligned} and `ftq_update_t` {valid, pc, taken, index, unaligned}, placed in the frontend package so the predictor can consume `ftq_update_t`.
- **Sub-module:** none required. Pointer arithmetic is inline; the entry array is flops.

## Test plan
- **Fill/drain:** reset, push 8 blocks (index 0x10..0x17) → `push_ready_o` drops after the 8th, `count_o = 8`. Commit 8 times → `count_o = 0`, `push_ready_o = 1`.
- **Resolve lookup:** push id 3 with index 0x1A5, unaligned = 1, then resolve id 3 with pc 0x8000_0046, taken = 1 → `upd_valid_o` for one cycle (latency per macro), `upd_index_o = 0x1A5`, `upd_unaligned_o = 1`, `upd_pc_o = 0x8000_0046`, `upd_taken_o = 1`.
- **Mispredict squash across wrap:** `head = 6`, push 5 entries (ids 6, 7, 0, 1, 2), mispredict on id 7 → `count_o = 2`, `push_id_o = 0`. A later resolve to id 1 → `resolve_drop_o = 1`, no update.
- **Same-cycle conflict:** push and mispredict in the same cycle → `push_ready_o = 0`, no entry written. Commit of the head plus mispredict on the head → `count_o = 0`.
- **Debug and flush:** resolve with `debug_mode_i = 1` → `upd_valid_o = 0`. `flush_i` with 5 live entries → `count_o = 0`, and a resolve issued in the same cycle gives no update.
